// File: rtl/obuf_arb_pkg.sv
// Shared types for the obuf read-port arbiter: FSM states, requester
// owner encoding and the credit counter width helper.
package obuf_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } arb_state_t;

  typedef enum logic {
    OWN_ST = 1'b0,
    OWN_PU = 1'b1
  } owner_t;

  // Counter must hold 0..credits inclusive
  function automatic int unsigned credit_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/obuf_credit_cnt.sv
// Per-requester downstream credit counter. Starts full, decrements on each
// issued read, increments on a credit return, saturates at CREDITS.
module obuf_credit_cnt
  import obuf_arb_pkg::*;
#(
  parameter int unsigned CREDITS = 4,
  parameter int unsigned CW      = credit_w(CREDITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          has_credit
);

  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  // Credit bookkeeping; simultaneous dec/inc cancel, returns at FULL are dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= FULL;
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end else if (inc && !dec && (count != FULL)) begin
      count <= count + CW'(1);
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/obuf_rd_arbiter.sv
// Arbitrates the obuf memory-side read port between the store DMA (st) and
// the post-processing unit (pu). Whole bursts are granted round-robin, one
// read is issued per cycle subject to per-requester credits, and read data
// is steered back to the owner one cycle after issue.
// Optional: define OBUF_RD_ARB_PERF_EN to add saturating stall counters.
module obuf_rd_arbiter
  import obuf_arb_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned LEN_W          = 8,
  parameter int unsigned CREDITS        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      st_req,
  input  logic [MEM_ADDR_WIDTH-1:0] st_addr,
  input  logic [LEN_W-1:0]          st_len,
  output logic                      st_grant,
  output logic                      st_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] st_rdata,
  output logic                      st_done,
  input  logic                      st_credit_ret,
  input  logic                      pu_req,
  input  logic [MEM_ADDR_WIDTH-1:0] pu_addr,
  input  logic [LEN_W-1:0]          pu_len,
  output logic                      pu_grant,
  output logic                      pu_rvalid,
  output logic [MEM_DATA_WIDTH-1:0] pu_rdata,
  output logic                      pu_done,
  input  logic                      pu_credit_ret,
  output logic                      mem_read_req,
  output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
  input  logic [MEM_DATA_WIDTH-1:0] mem_read_data
`ifdef OBUF_RD_ARB_PERF_EN
  ,
  output logic [31:0]               perf_st_stall,
  output logic [31:0]               perf_pu_stall
`endif
);

  localparam int unsigned CW = credit_w(CREDITS);

  arb_state_t                state_q;
  owner_t                    owner_q;
  owner_t                    last_q;
  owner_t                    rd_owner_q;
  logic                      rd_strobe_q;
  logic [MEM_ADDR_WIDTH-1:0] cur_addr_q;
  logic [LEN_W-1:0]          beats_q;

  logic          st_ok, pu_ok, can_grant, own_credit, issue;
  logic          st_issue, pu_issue, st_has, pu_has;
  logic [CW-1:0] st_cnt, pu_cnt;

  obuf_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_st_credit (
    .clk        (clk),
    .reset      (reset),
    .dec        (st_issue),
    .inc        (st_credit_ret),
    .count      (st_cnt),
    .has_credit (st_has)
  );

  obuf_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_pu_credit (
    .clk        (clk),
    .reset      (reset),
    .dec        (pu_issue),
    .inc        (pu_credit_ret),
    .count      (pu_cnt),
    .has_credit (pu_has)
  );

  // Arbitration, issue gating and return-path steering
  always_comb begin
    st_ok      = st_req && (st_len != '0);
    pu_ok      = pu_req && (pu_len != '0);
    // DRAIN accepts a new grant so bursts issue back-to-back
    can_grant  = !reset && ((state_q == IDLE) || (state_q == DRAIN));
    st_grant   = can_grant && st_ok && (!pu_ok || (last_q == OWN_PU));
    pu_grant   = can_grant && pu_ok && (!st_ok || (last_q == OWN_ST));
    own_credit = (owner_q == OWN_ST) ? st_has : pu_has;
    issue      = !reset && (state_q == BURST) && own_credit;
    st_issue   = issue && (owner_q == OWN_ST);
    pu_issue   = issue && (owner_q == OWN_PU);

    mem_read_req  = issue;
    mem_read_addr = issue ? cur_addr_q : '0;

    st_rvalid = rd_strobe_q && (rd_owner_q == OWN_ST);
    pu_rvalid = rd_strobe_q && (rd_owner_q == OWN_PU);
    st_rdata  = st_rvalid ? mem_read_data : '0;
    pu_rdata  = pu_rvalid ? mem_read_data : '0;
    // DRAIN is exactly the cycle the final beat returns
    st_done   = (state_q == DRAIN) && (owner_q == OWN_ST);
    pu_done   = (state_q == DRAIN) && (owner_q == OWN_PU);
  end

  // Burst FSM plus the one-cycle delayed issue strobe / owner tag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_ST;
      last_q      <= OWN_PU;
      rd_owner_q  <= OWN_ST;
      rd_strobe_q <= 1'b0;
      cur_addr_q  <= '0;
      beats_q     <= '0;
    end else begin
      rd_strobe_q <= issue;
      rd_owner_q  <= owner_q;
      case (state_q)
        IDLE, DRAIN: begin
          if (st_grant) begin
            owner_q    <= OWN_ST;
            last_q     <= OWN_ST;
            cur_addr_q <= st_addr;
            beats_q    <= st_len;
            state_q    <= BURST;
          end else if (pu_grant) begin
            owner_q    <= OWN_PU;
            last_q     <= OWN_PU;
            cur_addr_q <= pu_addr;
            beats_q    <= pu_len;
            state_q    <= BURST;
          end else begin
            state_q    <= IDLE;
          end
        end
        BURST: begin
          if (issue) begin
            cur_addr_q <= cur_addr_q + MEM_ADDR_WIDTH'(1);
            beats_q    <= beats_q - LEN_W'(1);
            if (beats_q == LEN_W'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Credit counters must never exceed their configured depth
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ((st_cnt <= CW'(CREDITS)) && (pu_cnt <= CW'(CREDITS)));
    end
  end

`ifdef OBUF_RD_ARB_PERF_EN
  logic st_stall, pu_stall;
  assign st_stall = !reset && (state_q == BURST) && (owner_q == OWN_ST) && !st_has;
  assign pu_stall = !reset && (state_q == BURST) && (owner_q == OWN_PU) && !pu_has;

  // Saturating zero-credit stall counters per requester
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_st_stall <= '0;
      perf_pu_stall <= '0;
    end else begin
      if (st_stall && (perf_st_stall != '1)) perf_st_stall <= perf_st_stall + 32'd1;
      if (pu_stall && (perf_pu_stall != '1)) perf_pu_stall <= perf_pu_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_obuf_rd_arbiter.sv
// Directed bench for obuf_rd_arbiter with a read-data scoreboard.
module tb_obuf_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_req, pu_req;
  logic [11:0] st_addr, pu_addr;
  logic [7:0]  st_len, pu_len;
  logic        st_grant, st_rvalid, st_done, st_credit_ret;
  logic        pu_grant, pu_rvalid, pu_done, pu_credit_ret;
  logic [63:0] st_rdata, pu_rdata;
  logic        mem_read_req;
  logic [11:0] mem_read_addr;
  logic [63:0] mem_read_data;

  always #5 clk = ~clk;

  obuf_rd_arbiter #(
    .MEM_ADDR_WIDTH (12),
    .MEM_DATA_WIDTH (64),
    .LEN_W          (8),
    .CREDITS        (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .st_req        (st_req),
    .st_addr       (st_addr),
    .st_len        (st_len),
    .st_grant      (st_grant),
    .st_rvalid     (st_rvalid),
    .st_rdata      (st_rdata),
    .st_done       (st_done),
    .st_credit_ret (st_credit_ret),
    .pu_req        (pu_req),
    .pu_addr       (pu_addr),
    .pu_len        (pu_len),
    .pu_grant      (pu_grant),
    .pu_rvalid     (pu_rvalid),
    .pu_rdata      (pu_rdata),
    .pu_done       (pu_done),
    .pu_credit_ret (pu_credit_ret),
    .mem_read_req  (mem_read_req),
    .mem_read_addr (mem_read_addr),
    .mem_read_data (mem_read_data)
  );

  // Memory contents are a fixed function of the address
  function automatic logic [63:0] mem_fn(input logic [11:0] a);
    return {4'hA, a, 4'h5, ~a, 20'hC0DE0, a};
  endfunction

  // One-cycle-latency memory model
  logic [11:0] mem_addr_q = '0;
  always_ff @(posedge clk) if (mem_read_req) mem_addr_q <= mem_read_addr;
  assign mem_read_data = mem_fn(mem_addr_q);

  typedef struct packed {
    logic        pu;
    logic [63:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic auto_st, auto_pu, man_st_ret, man_pu_ret;
  logic s_st_g, s_pu_g, s_rq, s_st_rv, s_pu_rv, s_st_dn, s_pu_dn;
  logic [11:0]  s_addr;
  logic [146:0] s_all;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample at negedge, run the scoreboard, drive credit returns, advance a cycle
  task automatic step();
    exp_t        e;
    logic [11:0] a;
    @(negedge clk);
    s_st_g  = st_grant;   s_pu_g  = pu_grant;
    s_rq    = mem_read_req; s_addr = mem_read_addr;
    s_st_rv = st_rvalid;  s_pu_rv = pu_rvalid;
    s_st_dn = st_done;    s_pu_dn = pu_done;
    s_all   = {st_grant, st_rvalid, st_rdata, st_done,
               pu_grant, pu_rvalid, pu_rdata, pu_done, mem_read_req, mem_read_addr};
    if (reset) begin
      sb.delete();
    end else begin
      if (st_rvalid || pu_rvalid) begin
        if (sb.size() == 0) begin
          chk("rv_unexpected", 256'({st_rvalid, pu_rvalid}), 256'(0));
        end else begin
          e = sb.pop_front();
          chk("rv_owner", 256'({st_rvalid, pu_rvalid}), e.pu ? 256'(1) : 256'(2));
          chk("rdata", 256'(e.pu ? pu_rdata : st_rdata), 256'(e.data));
          chk("rdata_other", 256'(e.pu ? st_rdata : pu_rdata), 256'(0));
          chk("done_last", 256'(e.pu ? pu_done : st_done), 256'(e.last));
        end
      end else begin
        chk("rdata_idle", 256'({st_rdata, pu_rdata}), 256'(0));
        if (st_done || pu_done) chk("stray_done", 256'({st_done, pu_done}), 256'(0));
      end
      if (st_grant) begin
        for (int unsigned i = 0; i < st_len; i++) begin
          a = st_addr + 12'(i);
          sb.push_back('{pu: 1'b0, data: mem_fn(a), last: (i == st_len - 1)});
        end
      end
      if (pu_grant) begin
        for (int unsigned i = 0; i < pu_len; i++) begin
          a = pu_addr + 12'(i);
          sb.push_back('{pu: 1'b1, data: mem_fn(a), last: (i == pu_len - 1)});
        end
      end
    end
    st_credit_ret = man_st_ret | (auto_st & st_rvalid);
    pu_credit_ret = man_pu_ret | (auto_pu & pu_rvalid);
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_done(input bit is_pu, input int unsigned rets, input int unsigned budget,
                                output int unsigned n, output bit seen);
    n = 0;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      if (is_pu) man_pu_ret = (i < rets);
      else       man_st_ret = (i < rets);
      step();
      n += 32'(s_rq);
      seen = is_pu ? s_pu_dn : s_st_dn;
    end
    man_pu_ret = 1'b0;
    man_st_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    bit          seen;
    logic        g;
    logic [11:0] ea;

    reset = 1'b1;
    {st_req, pu_req, st_addr, pu_addr, st_len, pu_len} = '0;
    {st_credit_ret, pu_credit_ret, auto_st, auto_pu, man_st_ret, man_pu_ret} = '0;
    step();
    step();
    chk("reset_outputs", 256'(s_all), 256'(0));

    // Single st burst, credits returned as data arrives
    reset = 1'b0; auto_st = 1'b1; auto_pu = 1'b1;
    st_req = 1'b1; st_addr = 12'h010; st_len = 8'd4;
    step();
    chk("t1_grant", 256'({s_st_g, s_pu_g}), 256'(2));
    st_req = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      ea = 12'h010 + 12'(i);
      chk("t1_req", 256'(s_rq), 256'(1));
      chk("t1_addr", 256'(s_addr), 256'(ea));
      chk("t1_rvalid", 256'(s_st_rv), 256'(i != 0));
    end
    step();
    chk("t1_done", 256'(s_st_dn), 256'(1));
    chk("t1_drain_noreq", 256'(s_rq), 256'(0));
    step();
    chk("t1_sb_empty", 256'(sb.size()), 256'(0));

    // Tie after reset: st first, pu granted during st's DRAIN
    reset = 1'b1;
    step();
    reset = 1'b0;
    st_req = 1'b1; st_addr = 12'h100; st_len = 8'd2;
    pu_req = 1'b1; pu_addr = 12'h200; pu_len = 8'd3;
    step();
    chk("t2_tie_grant", 256'({s_st_g, s_pu_g}), 256'(2));
    st_req = 1'b0;
    step();
    chk("t2_st_addr0", 256'({s_rq, s_addr, s_pu_g}), 256'({1'b1, 12'h100, 1'b0}));
    step();
    chk("t2_st_addr1", 256'({s_rq, s_addr}), 256'({1'b1, 12'h101}));
    step();
    chk("t2_drain_grant", 256'({s_st_g, s_pu_g, s_st_dn, s_rq}), 256'(4'b0110));
    pu_req = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      ea = 12'h200 + 12'(i);
      chk("t2_pu_addr", 256'({s_rq, s_addr}), 256'({1'b1, ea}));
    end
    step();
    chk("t2_pu_done", 256'(s_pu_dn), 256'(1));
    step();
    chk("t2_sb_empty", 256'(sb.size()), 256'(0));

    // pu len 8 against 4 credits, credits returned by hand
    auto_pu = 1'b0;
    pu_req = 1'b1; pu_addr = 12'h300; pu_len = 8'd8;
    step();
    chk("t3_grant", 256'({s_st_g, s_pu_g}), 256'(1));
    pu_req = 1'b0;
    n = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      step();
      n += 32'(s_rq);
    end
    chk("t3_reads_no_credit", 256'(n), 256'(4));
    n = 0;
    man_pu_ret = 1'b1;
    step();
    man_pu_ret = 1'b0;
    n += 32'(s_rq);
    for (int unsigned i = 0; i < 3; i++) begin
      step();
      n += 32'(s_rq);
    end
    chk("t3_reads_one_credit", 256'(n), 256'(1));
    run_until_done(1'b1, 3, 20, n, seen);
    chk("t3_reads_three_credits", 256'(n), 256'(3));
    chk("t3_done_seen", 256'(seen), 256'(1));
    step();
    chk("t3_sb_empty", 256'(sb.size()), 256'(0));

    // Address wrap
    st_req = 1'b1; st_addr = 12'hFFE; st_len = 8'd4;
    step();
    chk("t4_grant", 256'({s_st_g, s_pu_g}), 256'(2));
    st_req = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      ea = 12'hFFE + 12'(i);
      chk("t4_wrap_addr", 256'({s_rq, s_addr}), 256'({1'b1, ea}));
    end
    step();
    chk("t4_done", 256'(s_st_dn), 256'(1));
    step();
    chk("t4_sb_empty", 256'(sb.size()), 256'(0));

    // Reset in the middle of a 6-beat burst
    st_req = 1'b1; st_addr = 12'h400; st_len = 8'd6;
    step();
    chk("t5_grant", 256'(s_st_g), 256'(1));
    st_req = 1'b0;
    step();
    step();
    chk("t5_beat2", 256'({s_rq, s_addr}), 256'({1'b1, 12'h401}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("t5_outputs_after_reset", 256'(s_all), 256'(0));
    chk("t5_sb_empty", 256'(sb.size()), 256'(0));
    auto_st = 1'b0;
    st_req = 1'b1; st_addr = 12'h500; st_len = 8'd2;
    step();
    chk("t5_grant_a", 256'(s_st_g), 256'(1));
    st_req = 1'b0;
    run_until_done(1'b0, 0, 10, n, seen);
    chk("t5_reads_a", 256'({n[7:0], 7'd0, seen}), 256'({8'd2, 8'd1}));
    st_req = 1'b1; st_addr = 12'h600; st_len = 8'd2;
    step();
    chk("t5_grant_b", 256'(s_st_g), 256'(1));
    st_req = 1'b0;
    run_until_done(1'b0, 0, 10, n, seen);
    chk("t5_reads_b_full_credits", 256'({n[7:0], 7'd0, seen}), 256'({8'd2, 8'd1}));

    // len==0 is ignored; credit returns saturate at 4
    st_req = 1'b1; st_addr = 12'h700; st_len = 8'd0;
    n = 0; g = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      n += 32'(s_rq);
      g |= s_st_g;
    end
    chk("t6_len0_no_grant", 256'(g), 256'(0));
    chk("t6_len0_no_read", 256'(n), 256'(0));
    st_req = 1'b0;
    man_st_ret = 1'b1;
    for (int unsigned i = 0; i < 6; i++) step();
    man_st_ret = 1'b0;
    st_req = 1'b1; st_addr = 12'h800; st_len = 8'd6;
    step();
    chk("t6_grant", 256'(s_st_g), 256'(1));
    st_req = 1'b0;
    n = 0; g = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      step();
      n += 32'(s_rq);
      g |= s_st_dn;
    end
    chk("t6_saturated_reads", 256'(n), 256'(4));
    chk("t6_no_early_done", 256'(g), 256'(0));
    run_until_done(1'b0, 2, 20, n, seen);
    chk("t6_tail_reads", 256'({n[7:0], 7'd0, seen}), 256'({8'd2, 8'd1}));
    step();
    chk("t6_sb_empty", 256'(sb.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obuf_rd_arbiter.md
Name: obuf_rd_arbiter

Overview:
Arbitrates the obuf memory-side read port (mem_read_req/addr/data) between two burst requesters: the store DMA (st) and the post-processing unit (pu).
- Grants whole bursts round-robin.
- Issues one read per cycle, gated by per-requester downstream credits.
- Returns data tagged with a valid to the owning requester, accounting for the 1-cycle banked_ram read latency.
- Sits between obuf and the store/PU engines in the output path.

Parameters:
MEM_ADDR_WIDTH, 12, obuf memory-side read address width
MEM_DATA_WIDTH, 64, obuf memory-side read data width
LEN_W, 8, burst length field width (beats)
CREDITS, 4, downstream FIFO depth per requester; credit counters sized $clog2(CREDITS+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
st_req  in  1  store burst request; level, held until st_grant
st_addr  in  MEM_ADDR_WIDTH  store burst base address, sampled on grant cycle
st_len  in  LEN_W  store burst beats; 0 = request ignored, no grant
st_grant  out  1  one-cycle pulse: burst accepted
st_rvalid  out  1  st_rdata valid
st_rdata  out  MEM_DATA_WIDTH  read data to store engine
st_done  out  1  one-cycle pulse with last st_rvalid
st_credit_ret  in  1  store FIFO freed one entry
pu_req, pu_addr, pu_len, pu_grant, pu_rvalid, pu_rdata, pu_done, pu_credit_ret: same as st_*, for the PU
mem_read_req  out  1  obuf read strobe
mem_read_addr  out  MEM_ADDR_WIDTH  obuf read address
mem_read_data  in  MEM_DATA_WIDTH  obuf read data, valid 1 cycle after mem_read_req

Behaviour:
- States: IDLE, BURST, DRAIN.
- IDLE:
  - Any req with len!=0 -> grant pulse, latch addr/len/owner, go to BURST next cycle.
  - Both requesting: grant the one not last served. last_served resets to pu, so st wins the first tie.
  - req with len==0 is ignored and no grant is issued.
- BURST:
  - Each cycle the owner has credit>0: mem_read_req=1, mem_read_addr=cur_addr, cur_addr+=1 (wraps mod 2^MEM_ADDR_WIDTH), beats_left-=1.
  - Credit==0 -> mem_read_req=0; burst stalls with no loss.
  - After the last beat is issued -> DRAIN.
- DRAIN: one cycle for the final beat's data return; done pulse; -> IDLE. A new grant may be issued in that same DRAIN cycle (back-to-back bursts, no bubble on the issue side).
- Return path:
  - Owner tag and issue strobe are registered 1 cycle.
  - {st|pu}_rvalid = registered strobe and owner match.
  - rdata = mem_read_data, muxed to the owner, zero otherwise.
  - done coincides with the rvalid of the last beat.
- Credits:
  - Reset to CREDITS; decrement on issue, increment on credit_ret; simultaneous issue and credit_ret -> unchanged.
  - credit_ret at CREDITS is ignored (saturate).
  - Credits are never negative: issue is impossible at 0.
- Latency: first mem_read_req occurs 1 cycle after grant; first rvalid 2 cycles after grant.
- Reset, including mid-burst: all outputs 0; state IDLE; credits = CREDITS; last_served = pu; in-flight beats dropped, no done.
- Requester changing addr/len while req is held before grant: the value on the grant cycle is used.

Optional Feature:
Macro OBUF_RD_ARB_PERF_EN.
- Defined: adds outputs perf_st_stall and perf_pu_stall (32-bit each, saturating). Each counts BURST cycles where its owner is stalled on zero credit. Both clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package obuf_arb_pkg:
  - State enum {IDLE, BURST, DRAIN}.
  - Owner encoding OWN_ST=0, OWN_PU=1.
  - Credit width function.
- Sub-module obuf_credit_cnt (parameter CREDITS; inputs dec/inc; outputs count/has_credit), instantiated once per requester.

Test Plan:
- st_req, addr=0x010, len=4, credit returned immediately -> st_grant at T, mem_read_req T+1..T+4 with addr 0x010..0x013, st_rvalid T+2..T+5, st_done at T+5.
- st and pu request same cycle after reset -> st granted first. pu granted in st's DRAIN cycle; pu addresses follow without an issue bubble.
- pu len=8 with CREDITS=4 and no credit_ret -> exactly 4 reads then stall. Return 1 credit -> exactly 1 more read. Return 3 -> burst completes, pu_done after 8th rvalid.
- addr=0xFFE, len=4 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- Assert reset after 2 of 6 beats -> next cycle all outputs 0, no done. A new st burst len=2 then completes normally with full credits.
- st_len=0 held 5 cycles -> no grant, no mem_read_req. credit_ret while at CREDITS -> count stays 4 (checked via 5 reads being impossible).
